// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
//   15 kHz raster timing constants for PAL and NTSC, plus the shared types
//   used by the sync generator and its axis counters.
//   Contents:
//     CNT_W           width of the horizontal and vertical counters
//     h_timing_t      horizontal geometry (total / active / porch / sync)
//     v_timing_t      vertical geometry, one set per video standard
//     video_mode_e    latched video standard
//     vid_out_t       bundle of registered video outputs and its reset value
//     in_window()     half-open range test used by the sync decode
// ---------------------------------------------------------------------------
package video_timing_pkg;

    localparam int CNT_W = 9;

    // Horizontal: 416 clocks = 64 us at 6.5 MHz.
    localparam int H_TOTAL  = 416;
    localparam int H_ACTIVE = 320;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 31;

    // PAL lines.
    localparam int PV_TOTAL  = 312;
    localparam int PV_ACTIVE = 256;
    localparam int PV_FP     = 16;
    localparam int PV_SYNC   = 3;

    // NTSC lines.
    localparam int NV_TOTAL  = 262;
    localparam int NV_ACTIVE = 240;
    localparam int NV_FP     = 3;
    localparam int NV_SYNC   = 3;

    // Shortest line the downstream scandoubler will lock to.
    localparam int MIN_LINE = 128;

    typedef struct packed {
        logic [CNT_W-1:0] total;
        logic [CNT_W-1:0] active;
        logic [CNT_W-1:0] fp;
        logic [CNT_W-1:0] sync;
    } h_timing_t;

    typedef struct packed {
        logic [CNT_W-1:0] total;
        logic [CNT_W-1:0] active;
        logic [CNT_W-1:0] fp;
        logic [CNT_W-1:0] sync;
    } v_timing_t;

    localparam h_timing_t H_TIMING = '{
        total:  CNT_W'(H_TOTAL),
        active: CNT_W'(H_ACTIVE),
        fp:     CNT_W'(H_FP),
        sync:   CNT_W'(H_SYNC)
    };

    localparam v_timing_t PAL_TIMING = '{
        total:  CNT_W'(PV_TOTAL),
        active: CNT_W'(PV_ACTIVE),
        fp:     CNT_W'(PV_FP),
        sync:   CNT_W'(PV_SYNC)
    };

    localparam v_timing_t NTSC_TIMING = '{
        total:  CNT_W'(NV_TOTAL),
        active: CNT_W'(NV_ACTIVE),
        fp:     CNT_W'(NV_FP),
        sync:   CNT_W'(NV_SYNC)
    };

    typedef enum logic {
        MODE_PAL  = 1'b0,
        MODE_NTSC = 1'b1
    } video_mode_e;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic       hsync_n;
        logic       vsync_n;
        logic       csync_n;
        logic       blank;
        logic       line_start;
        logic       frame_irq;
    } vid_out_t;

    localparam vid_out_t VID_OUT_RESET = '{
        r:          3'd0,
        g:          3'd0,
        b:          3'd0,
        hsync_n:    1'b1,
        vsync_n:    1'b1,
        csync_n:    1'b1,
        blank:      1'b1,
        line_start: 1'b0,
        frame_irq:  1'b0
    };

    // True when lo <= pos < lo+len.
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input int               lo,
                                       input int               len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage : video_timing_pkg

// File: rtl/video_axis_counter.sv
// ---------------------------------------------------------------------------
// video_axis_counter
//   Enabled wrap counter for one raster axis. Counts 0..last_i and wraps to 0.
//   tc_o is high in the enabled cycle in which the counter wraps, so the
//   horizontal tc_o can directly enable the vertical counter.
//   Ports:
//     clk_i    pixel clock
//     rst_i    async, active-high reset (count -> 0)
//     en_i     advance the counter this cycle
//     last_i   terminal value (total-1); may change only when count is 0
//     count_o  live counter value
//     tc_o     wrap strobe (en_i && count at or beyond last_i)
// ---------------------------------------------------------------------------
module video_axis_counter
    import video_timing_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        // >= rather than == so a count left beyond a shortened total still wraps.
        tc_o    = en_i && (count_q >= last_i);
        if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : video_axis_counter

// File: rtl/video_sync_gen.sv
// ---------------------------------------------------------------------------
// video_sync_gen
//   15 kHz raster timing generator. Produces PAL or NTSC line/frame counters,
//   blanking, syncs and gated pixel data for the scandoubler input.
//   The video standard is latched only when both counters wrap, so a frame
//   always finishes with the geometry it started with.
//   Every derived output is registered one cycle after the (hc,vc) it is
//   decoded from; hc/vc themselves are the live counters.
//   Ports:
//     clkvideo             pixel clock
//     reset                async, active-high reset
//     ntsc                 requested standard (0=PAL, 1=NTSC), used at frame wrap
//     ri, gi, bi           pixel for the current hc/vc
//     hc, vc               live horizontal / vertical counters
//     ro, go, bo           pixel out, 0 outside the active area
//     hsync_n, vsync_n     active-low line / frame sync
//     csync_n              hsync_n & vsync_n, registered
//     blank                1 outside the active area
//     line_start           pulse on the first cycle of every line
//     frame_irq            pulse on the first cycle of vsync
// ---------------------------------------------------------------------------
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter h_timing_t H      = H_TIMING,
    parameter v_timing_t PAL_V  = PAL_TIMING,
    parameter v_timing_t NTSC_V = NTSC_TIMING
) (
    input  logic             clkvideo,
    input  logic             reset,
    input  logic             ntsc,
    input  logic [2:0]       ri,
    input  logic [2:0]       gi,
    input  logic [2:0]       bi,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic [2:0]       ro,
    output logic [2:0]       go,
    output logic [2:0]       bo,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             csync_n,
    output logic             blank,
    output logic             line_start,
    output logic             frame_irq
);

    // ---------------------------------------------------------------------
    // Geometry sanity, evaluated at elaboration.
    // ---------------------------------------------------------------------
    if (int'(H.active) + int'(H.fp) + int'(H.sync) > int'(H.total)) begin : g_bad_hsync
        $fatal(1, "video_sync_gen: hsync does not fit inside the line");
    end
    if (int'(H.total) < MIN_LINE) begin : g_short_line
        $fatal(1, "video_sync_gen: line shorter than the scandoubler minimum");
    end
    if (int'(PAL_V.active) + int'(PAL_V.fp) + int'(PAL_V.sync) > int'(PAL_V.total)) begin : g_bad_pal
        $fatal(1, "video_sync_gen: PAL vsync does not fit inside the frame");
    end
    if (int'(NTSC_V.active) + int'(NTSC_V.fp) + int'(NTSC_V.sync) > int'(NTSC_V.total)) begin : g_bad_ntsc
        $fatal(1, "video_sync_gen: NTSC vsync does not fit inside the frame");
    end

    // ---------------------------------------------------------------------
    // Counters
    // ---------------------------------------------------------------------
    video_mode_e mode_q;
    video_mode_e mode_d;
    v_timing_t   v_sel;
    logic        h_tc;
    logic        v_tc;

    always_comb begin
        v_sel = (mode_q == MODE_NTSC) ? NTSC_V : PAL_V;
    end

    video_axis_counter u_hcnt (
        .clk_i   (clkvideo),
        .rst_i   (reset),
        .en_i    (1'b1),
        .last_i  (H.total - 1'b1),
        .count_o (hc),
        .tc_o    (h_tc)
    );

    // The vertical total follows the latched mode, which only changes on the
    // same edge that returns vc to 0, so vc never sits beyond its total.
    video_axis_counter u_vcnt (
        .clk_i   (clkvideo),
        .rst_i   (reset),
        .en_i    (h_tc),
        .last_i  (v_sel.total - 1'b1),
        .count_o (vc),
        .tc_o    (v_tc)
    );

    // ---------------------------------------------------------------------
    // Mode latch: sampled only on the frame wrap.
    // ---------------------------------------------------------------------
    always_comb begin
        mode_d = mode_q;
        if (h_tc && v_tc) begin
            mode_d = ntsc ? MODE_NTSC : MODE_PAL;
        end
    end

    always_ff @(posedge clkvideo or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_PAL;
        end else begin
            mode_q <= mode_d;
        end
    end

    // ---------------------------------------------------------------------
    // Decode on the live (hc,vc) and register one cycle later.
    // ---------------------------------------------------------------------
    logic     act;
    logic     hs;
    logic     vs;
    vid_out_t out_d;
    vid_out_t out_q;

    always_comb begin
        act = (hc < H.active) && (vc < v_sel.active);
        hs  = in_window(hc, int'(H.active) + int'(H.fp), int'(H.sync));
        vs  = in_window(vc, int'(v_sel.active) + int'(v_sel.fp), int'(v_sel.sync));

        out_d            = VID_OUT_RESET;
        out_d.r          = act ? ri : 3'd0;
        out_d.g          = act ? gi : 3'd0;
        out_d.b          = act ? bi : 3'd0;
        out_d.blank      = ~act;
        out_d.hsync_n    = ~hs;
        out_d.vsync_n    = ~vs;
        // Built from the same decode terms so it lands on the same edge as
        // hsync_n/vsync_n and cannot glitch.
        out_d.csync_n    = ~(hs | vs);
        out_d.line_start = (hc == '0);
        out_d.frame_irq  = (hc == '0) &&
                           (int'(vc) == int'(v_sel.active) + int'(v_sel.fp));
    end

    always_ff @(posedge clkvideo or posedge reset) begin
        if (reset) begin
            out_q <= VID_OUT_RESET;
        end else begin
            out_q <= out_d;
        end
    end

    assign ro         = out_q.r;
    assign go         = out_q.g;
    assign bo         = out_q.b;
    assign hsync_n    = out_q.hsync_n;
    assign vsync_n    = out_q.vsync_n;
    assign csync_n    = out_q.csync_n;
    assign blank      = out_q.blank;
    assign line_start = out_q.line_start;
    assign frame_irq  = out_q.frame_irq;

endmodule : video_sync_gen

// File: tb/tb_video_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_video_sync_gen
//   Two instances share clock, reset and inputs:
//     dut_s  full 416-clock lines, shortened frames (PAL 40 lines, NTSC 30)
//            so whole frames, vsync and mode changes fit in a short run.
//            PAL:  active 24, fp 4, sync 3 -> vsync lines 28..30
//            NTSC: active 20, fp 3, sync 3 -> vsync lines 23..25
//     dut_f  default PAL/NTSC geometry, checked over its first 40 lines.
// ---------------------------------------------------------------------------
module tb_video_sync_gen;
    import video_timing_pkg::*;

    localparam v_timing_t TB_PAL  = '{total: 9'd40, active: 9'd24, fp: 9'd4, sync: 9'd3};
    localparam v_timing_t TB_NTSC = '{total: 9'd30, active: 9'd20, fp: 9'd3, sync: 9'd3};

    logic       clkvideo = 1'b0;
    logic       reset    = 1'b1;
    logic       ntsc     = 1'b0;
    logic [2:0] ri = 3'd0, gi = 3'd0, bi = 3'd0;

    logic [8:0] hc, vc;
    logic [2:0] ro, go, bo;
    logic       hsync_n, vsync_n, csync_n, blank, line_start, frame_irq;

    logic [8:0] f_hc, f_vc;
    logic [2:0] f_ro, f_go, f_bo;
    logic       f_hsync_n, f_vsync_n, f_csync_n, f_blank, f_line_start, f_frame_irq;

    video_sync_gen #(.PAL_V(TB_PAL), .NTSC_V(TB_NTSC)) dut_s (
        .clkvideo(clkvideo), .reset(reset), .ntsc(ntsc),
        .ri(ri), .gi(gi), .bi(bi), .hc(hc), .vc(vc),
        .ro(ro), .go(go), .bo(bo),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .csync_n(csync_n),
        .blank(blank), .line_start(line_start), .frame_irq(frame_irq)
    );

    video_sync_gen dut_f (
        .clkvideo(clkvideo), .reset(reset), .ntsc(ntsc),
        .ri(ri), .gi(gi), .bi(bi), .hc(f_hc), .vc(f_vc),
        .ro(f_ro), .go(f_go), .bo(f_bo),
        .hsync_n(f_hsync_n), .vsync_n(f_vsync_n), .csync_n(f_csync_n),
        .blank(f_blank), .line_start(f_line_start), .frame_irq(f_frame_irq)
    );

    always #5 clkvideo = ~clkvideo;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Per-frame statistics for dut_s (plus a few for dut_f).
    int cyc, max_vc, ls_cnt, ls_err;
    int hs_low, hs_first_hc, hs_last_hc;
    int vs_low, vs_first_vc, vs_first_hc, vs_last_vc, vs_last_hc;
    int irq_cnt, irq_vc, irq_hc;
    int rgb_on, rgb_err, blank_err, csync_err;
    int ro_at_319, ro_at_320;
    int f_hs_low, f_vs_low, f_act, f_ls, f_cs_err;

    // Runs dut_s from a sample where it shows (0,0) until it shows (0,0) again.
    // Outputs seen after each edge are compared against the (hc,vc) sampled
    // before that edge. pat=1 drives a position-dependent pixel, else 7/7/7.
    task automatic run_frame(input int v_active, input bit pat,
                             input int tog_vc, input logic tog_val);
        int p_hc, p_vc;
        logic [8:0] exp_rgb;
        bit act;
        bit done;
        cyc = 0; max_vc = 0; ls_cnt = 0; ls_err = 0;
        hs_low = 0; hs_first_hc = -1; hs_last_hc = -1;
        vs_low = 0; vs_first_vc = -1; vs_first_hc = -1; vs_last_vc = -1; vs_last_hc = -1;
        irq_cnt = 0; irq_vc = -1; irq_hc = -1;
        rgb_on = 0; rgb_err = 0; blank_err = 0; csync_err = 0;
        ro_at_319 = -1; ro_at_320 = -1;
        f_hs_low = 0; f_vs_low = 0; f_act = 0; f_ls = 0; f_cs_err = 0;
        done = 1'b0;
        while (!done) begin
            p_hc = int'(hc);
            p_vc = int'(vc);
            if (pat) begin
                ri = hc[2:0]; gi = hc[5:3]; bi = vc[2:0];
            end else begin
                ri = 3'd7; gi = 3'd7; bi = 3'd7;
            end
            if (p_vc == tog_vc && p_hc == 0) ntsc = tog_val;
            exp_rgb = {ri, gi, bi};
            @(posedge clkvideo); #1;
            cyc++;
            act = (p_hc < 320) && (p_vc < v_active);
            if (!act) exp_rgb = 9'd0;
            if (p_vc > max_vc) max_vc = p_vc;
            if (line_start) ls_cnt++;
            if (line_start !== (p_hc == 0)) ls_err++;
            if (!hsync_n) begin
                if (hs_low == 0) hs_first_hc = p_hc;
                hs_last_hc = p_hc;
                hs_low++;
            end
            if (!vsync_n) begin
                if (vs_low == 0) begin vs_first_vc = p_vc; vs_first_hc = p_hc; end
                vs_last_vc = p_vc; vs_last_hc = p_hc;
                vs_low++;
            end
            if (frame_irq) begin irq_cnt++; irq_vc = p_vc; irq_hc = p_hc; end
            if ({ro, go, bo} == 9'h1FF) rgb_on++;
            if ({ro, go, bo} !== exp_rgb) rgb_err++;
            if (blank !== !act) blank_err++;
            if (csync_n !== (hsync_n & vsync_n)) csync_err++;
            if (p_vc == 0 && p_hc == 319) ro_at_319 = int'(ro);
            if (p_vc == 0 && p_hc == 320) ro_at_320 = int'(ro);
            if (!f_hsync_n) f_hs_low++;
            if (!f_vsync_n) f_vs_low++;
            if (!f_blank) f_act++;
            if (f_line_start) f_ls++;
            if (f_csync_n !== (f_hsync_n & f_vsync_n)) f_cs_err++;
            if ((hc == 9'd0 && vc == 9'd0) || cyc >= 20000) done = 1'b1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_outs"}, {ro, go, bo, hsync_n, vsync_n, csync_n, blank, line_start, frame_irq},
              15'b000000000_111100);
        check({tag, "_cnt"}, {hc, vc}, 18'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        ri = 3'd7; gi = 3'd7; bi = 3'd7;
        repeat (3) @(posedge clkvideo);
        #1;
        // Reset state, with a live pixel on the inputs that must not leak out.
        check_idle("reset");
        check("reset_f_outs", {f_ro, f_hsync_n, f_vsync_n, f_csync_n, f_blank, f_line_start, f_frame_irq},
              9'b000_111100);
        check("reset_f_cnt", {f_hc, f_vc}, 18'd0);

        @(negedge clkvideo);
        reset = 1'b0;

        // Frame 1: PAL, constant 7/7/7.
        run_frame(24, 1'b0, -1, 1'b0);
        check("pal1_len", cyc, 16640);
        check("pal1_max_vc", max_vc, 39);
        check("pal1_line_starts", ls_cnt, 40);
        check("pal1_line_start_pos", ls_err, 0);
        check("hsync_low_cycles", hs_low, 31 * 40);
        check("hsync_first_after_hc", hs_first_hc, 336);
        check("hsync_last_after_hc", hs_last_hc, 366);
        check("pal1_vsync_low", vs_low, 3 * 416);
        check("pal1_vsync_first", {vs_first_vc[15:0], vs_first_hc[15:0]}, {16'd28, 16'd0});
        check("pal1_vsync_last", {vs_last_vc[15:0], vs_last_hc[15:0]}, {16'd30, 16'd415});
        check("pal1_irq_cnt", irq_cnt, 1);
        check("pal1_irq_pos", {irq_vc[15:0], irq_hc[15:0]}, {16'd28, 16'd0});
        check("rgb7_cycles", rgb_on, 320 * 24);
        check("rgb7_errs", rgb_err, 0);
        check("pal1_blank_errs", blank_err, 0);
        check("ro_after_hc319", ro_at_319, 7);
        check("ro_after_hc320", ro_at_320, 0);
        check("pal1_csync_errs", csync_err, 0);
        check("full_hsync_low", f_hs_low, 31 * 40);
        check("full_vsync_low", f_vs_low, 0);
        check("full_active", f_act, 320 * 40);
        check("full_line_starts", f_ls, 40);
        check("full_csync_errs", f_cs_err, 0);
        check("full_cnt_after_40_lines", {f_vc, f_hc}, {9'd40, 9'd0});

        // Frame 2: PAL; NTSC requested at vc=35 (beyond the NTSC total).
        run_frame(24, 1'b1, 35, 1'b1);
        check("pal2_len", cyc, 16640);
        check("pal2_max_vc", max_vc, 39);
        check("pal2_rgb_errs", rgb_err, 0);
        check("pal2_blank_errs", blank_err, 0);

        // Frame 3: NTSC taken at the wrap.
        run_frame(20, 1'b1, -1, 1'b1);
        check("ntsc_len", cyc, 12480);
        check("ntsc_max_vc", max_vc, 29);
        check("ntsc_vsync_low", vs_low, 3 * 416);
        check("ntsc_vsync_first_vc", vs_first_vc, 23);
        check("ntsc_vsync_last_vc", vs_last_vc, 25);
        check("ntsc_irq_cnt", irq_cnt, 1);
        check("ntsc_irq_vc", irq_vc, 23);
        check("ntsc_rgb_errs", rgb_err, 0);
        check("ntsc_blank_errs", blank_err, 0);
        check("ntsc_csync_errs", csync_err, 0);

        // Frame 4 (NTSC): reset mid-line at hc=200, vc=5.
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            if (hc == 9'd200 && vc == 9'd5) found = 1'b1;
            else begin @(posedge clkvideo); #1; end
        end
        check("reach_hc200_vc5", found, 1);
        reset = 1'b1;
        #1;
        check_idle("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clkvideo); #1;
            check_idle("rst_hold");
        end
        @(negedge clkvideo);
        reset = 1'b0;

        // ntsc still 1, but reset restored PAL for this frame.
        run_frame(24, 1'b0, -1, 1'b1);
        check("post_rst_len", cyc, 16640);
        check("post_rst_max_vc", max_vc, 39);
        check("post_rst_vsync_first_vc", vs_first_vc, 28);
        check("post_rst_line_starts", ls_cnt, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_video_sync_gen
